// File: rtl/ir_cmd_sequencer_if.sv
// Signal bundle between the IR command sequencer, its IR decoder and the command consumer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface ir_cmd_sequencer_if;
  localparam int unsigned FRAME_W = 32;
  localparam int unsigned BYTE_W  = 8;

  logic               enable;
  logic               frame_push;
  logic [FRAME_W-1:0] frame_data;
  logic               cmd_ready;
  logic               dec_start;
  logic               dec_restart;
  logic               cmd_valid;
  logic [BYTE_W-1:0]  cmd_addr;
  logic [BYTE_W-1:0]  cmd_code;
  logic               cmd_repeat;
  logic [BYTE_W-1:0]  err_count;
  logic               overrun;

  modport master (
    output enable, frame_push, frame_data, cmd_ready,
    input  dec_start, dec_restart, cmd_valid, cmd_addr, cmd_code, cmd_repeat, err_count, overrun
  );

  modport slave (
    input  enable, frame_push, frame_data, cmd_ready,
    output dec_start, dec_restart, cmd_valid, cmd_addr, cmd_code, cmd_repeat, err_count, overrun
  );
endinterface

// File: rtl/ir_cmd_sequencer.sv
// Arms an IR decoder, validates complement-coded frames and holds decoded commands until the
// consumer accepts them; flags repeats, counts rejected frames and records overruns.
module ir_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4_000_000,
  parameter int unsigned REPEAT_WINDOW  = 12_000_000
) (
  input  logic              clk,
  input  logic              reset,
  ir_cmd_sequencer_if.slave bus
);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WIN_W   = $clog2(REPEAT_WINDOW + 1);
  localparam int unsigned FRAME_W = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam logic [BYTE_W-1:0] ERR_MAX = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LISTEN,
    S_CHECK,
    S_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 have_last_q, have_last_d;
  logic [BYTE_W-1:0]    last_addr_q, last_addr_d;
  logic [BYTE_W-1:0]    last_code_q, last_code_d;
  logic                 dec_start_q, dec_start_d;
  logic                 dec_restart_q, dec_restart_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [BYTE_W-1:0]    cmd_addr_q, cmd_addr_d;
  logic [BYTE_W-1:0]    cmd_code_q, cmd_code_d;
  logic                 cmd_repeat_q, cmd_repeat_d;
  logic [BYTE_W-1:0]    err_q, err_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_good;

  assign frame_good = (frame_q[23:16] == ~frame_q[31:24]) && (frame_q[7:0] == ~frame_q[15:8]);

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    timeout_d    = 1'b0;
    win_cnt_d    = (win_cnt_q == WIN_W'(REPEAT_WINDOW)) ? win_cnt_q : win_cnt_q + WIN_W'(1);
    frame_d      = frame_q;
    have_last_d  = have_last_q;
    last_addr_d  = last_addr_q;
    last_code_d  = last_code_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_code_d   = cmd_code_q;
    cmd_repeat_d = cmd_repeat_q;
    err_d        = err_q;
    overrun_d    = overrun_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable) state_d = S_ARM;
      end
      S_ARM: begin
        to_cnt_d = '0;
        state_d  = S_LISTEN;
      end
      S_LISTEN: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // A frame completing this cycle beats both disable and timeout
        if (bus.frame_push) begin
          frame_d = bus.frame_data;
          state_d = S_CHECK;
        end else if (!bus.enable) begin
          state_d = S_IDLE;
        end else if (timeout_q) begin
          state_d = S_ARM;
        end else begin
          timeout_d = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        end
      end
      S_CHECK: begin
        if (frame_good) begin
          state_d      = S_HOLD;
          cmd_addr_d   = frame_q[31:24];
          cmd_code_d   = frame_q[15:8];
          cmd_repeat_d = have_last_q && (frame_q[31:24] == last_addr_q) &&
                         (frame_q[15:8] == last_code_q) && (win_cnt_q < WIN_W'(REPEAT_WINDOW));
        end else begin
          state_d = S_ARM;
          if (err_q != ERR_MAX) err_d = err_q + BYTE_W'(1);
        end
      end
      S_HOLD: begin
        if (bus.frame_push) overrun_d = 1'b1;
        if (bus.cmd_ready) begin
          state_d     = bus.enable ? S_ARM : S_IDLE;
          have_last_d = 1'b1;
          last_addr_d = cmd_addr_q;
          last_code_d = cmd_code_q;
          win_cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    dec_start_d   = (state_d == S_LISTEN);
    dec_restart_d = (state_d == S_ARM);
    cmd_valid_d   = (state_d == S_HOLD);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      to_cnt_q      <= '0;
      timeout_q     <= 1'b0;
      win_cnt_q     <= '0;
      frame_q       <= '0;
      have_last_q   <= 1'b0;
      last_addr_q   <= '0;
      last_code_q   <= '0;
      dec_start_q   <= 1'b0;
      dec_restart_q <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_code_q    <= '0;
      cmd_repeat_q  <= 1'b0;
      err_q         <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      timeout_q     <= timeout_d;
      win_cnt_q     <= win_cnt_d;
      frame_q       <= frame_d;
      have_last_q   <= have_last_d;
      last_addr_q   <= last_addr_d;
      last_code_q   <= last_code_d;
      dec_start_q   <= dec_start_d;
      dec_restart_q <= dec_restart_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_code_q    <= cmd_code_d;
      cmd_repeat_q  <= cmd_repeat_d;
      err_q         <= err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.dec_start   = dec_start_q;
  assign bus.dec_restart = dec_restart_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_addr    = cmd_addr_q;
  assign bus.cmd_code    = cmd_code_q;
  assign bus.cmd_repeat  = cmd_repeat_q;
  assign bus.err_count   = err_q;
  assign bus.overrun     = overrun_q;
endmodule
